// File: rtl/srs_regfile_if.sv
// Bus bundle for srs_regfile: enable, two read ports, core write port,
// sample-load port and the registered read/collision outputs.
interface srs_regfile_if #(
    parameter int WIDTH  = 3,
    parameter int DATA_W = 16
);
    logic              en;
    logic              re1;
    logic              re2;
    logic [WIDTH-1:0]  ar1;
    logic [WIDTH-1:0]  ar2;
    logic              we;
    logic [WIDTH-1:0]  ard;
    logic [DATA_W-1:0] wd;
    logic              smp_we;
    logic [DATA_W-1:0] smp_d;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_vld;
    logic              rd2_vld;
    logic              wr_collide;

    modport master (
        output en, re1, re2, ar1, ar2, we, ard, wd, smp_we, smp_d,
        input  rd1, rd2, rd1_vld, rd2_vld, wr_collide
    );

    modport slave (
        input  en, re1, re2, ar1, ar2, we, ard, wd, smp_we, smp_d,
        output rd1, rd2, rd1_vld, rd2_vld, wr_collide
    );
endinterface

// File: rtl/srs_regfile.sv
// MAC datapath register file: two registered read ports, a core write port and a
// sample-load port into SAMPLE_REG. Define REGFILE_BYPASS_EN for write-first reads.
module srs_regfile #(
    parameter int WIDTH      = 3,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_REG = 0
) (
    input  logic         clk,
    input  logic         rst,
    srs_regfile_if.slave bus
);
    localparam int               DEPTH    = 2 ** WIDTH;
    localparam logic [WIDTH-1:0] SMP_ADDR = WIDTH'(SAMPLE_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              collide;
    logic              core_wr;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    // The sample write owns SAMPLE_REG; a same-cycle core write there is dropped.
    assign collide = bus.we && bus.smp_we && (bus.ard == SMP_ADDR);
    assign core_wr = bus.we && !collide;

    always_comb begin
        // NOTE: give every comb output a default first so no path leaves it unassigned (latch).
        rd1_next = mem[bus.ar1];
        rd2_next = mem[bus.ar2];
`ifdef REGFILE_BYPASS_EN
        // Sample write is applied last so it wins over the core write.
        if (core_wr && (bus.ard == bus.ar1))    rd1_next = bus.wd;
        if (bus.smp_we && (SMP_ADDR == bus.ar1)) rd1_next = bus.smp_d;
        if (core_wr && (bus.ard == bus.ar2))    rd2_next = bus.wd;
        if (bus.smp_we && (SMP_ADDR == bus.ar2)) rd2_next = bus.smp_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bus.rd1        <= '0;
            bus.rd2        <= '0;
            bus.rd1_vld    <= 1'b0;
            bus.rd2_vld    <= 1'b0;
            bus.wr_collide <= 1'b0;
        end else if (bus.en) begin
            // NOTE: non-blocking updates let reads below see the pre-edge array contents.
            if (core_wr)    mem[bus.ard]  <= bus.wd;
            if (bus.smp_we) mem[SMP_ADDR] <= bus.smp_d;
            if (bus.re1)    bus.rd1       <= rd1_next;
            if (bus.re2)    bus.rd2       <= rd2_next;
            bus.rd1_vld    <= bus.re1;
            bus.rd2_vld    <= bus.re2;
            bus.wr_collide <= collide;
        end else begin
            bus.rd1_vld    <= 1'b0;
            bus.rd2_vld    <= 1'b0;
            bus.wr_collide <= 1'b0;
        end
    end
endmodule

// File: tb/tb_srs_regfile.sv
// Self-checking bench for srs_regfile: table of per-cycle vectors plus a
// hand-written asynchronous-reset sequence. Honours REGFILE_BYPASS_EN.
module tb_srs_regfile;
    localparam int WIDTH  = 3;
    localparam int DATA_W = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string             name;
        logic              en, re1, re2;
        logic [WIDTH-1:0]  ar1, ar2;
        logic              we;
        logic [WIDTH-1:0]  ard;
        logic [DATA_W-1:0] wd;
        logic              smp_we;
        logic [DATA_W-1:0] smp_d;
        logic [DATA_W-1:0] e_rd1, e_rd2;
        logic              e_v1, e_v2, e_col;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    srs_regfile_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();

    srs_regfile #(.WIDTH(WIDTH), .DATA_W(DATA_W), .SAMPLE_REG(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                              input logic v1, input logic v2, input logic col);
        check({name, ".rd1"}, bus.rd1, e1);
        check({name, ".rd2"}, bus.rd2, e2);
        check({name, ".rd1_vld"}, 16'(bus.rd1_vld), 16'(v1));
        check({name, ".rd2_vld"}, 16'(bus.rd2_vld), 16'(v2));
        check({name, ".wr_collide"}, 16'(bus.wr_collide), 16'(col));
    endtask

    task automatic drive(input vec_t v);
        bus.en = v.en;   bus.re1 = v.re1; bus.re2 = v.re2;
        bus.ar1 = v.ar1; bus.ar2 = v.ar2;
        bus.we = v.we;   bus.ard = v.ard; bus.wd = v.wd;
        bus.smp_we = v.smp_we; bus.smp_d = v.smp_d;
    endtask

    // Drive on the falling edge, check 1 time unit after the following rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(v.name, v.e_rd1, v.e_rd2, v.e_v1, v.e_v2, v.e_col);
    endtask

    function automatic vec_t mk(input string name, input logic en, input logic re1, input logic re2,
                                input logic [WIDTH-1:0] ar1, input logic [WIDTH-1:0] ar2,
                                input logic we, input logic [WIDTH-1:0] ard, input logic [DATA_W-1:0] wd,
                                input logic smp_we, input logic [DATA_W-1:0] smp_d,
                                input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                                input logic v1, input logic v2, input logic col);
        vec_t v;
        v.name = name; v.en = en; v.re1 = re1; v.re2 = re2; v.ar1 = ar1; v.ar2 = ar2;
        v.we = we; v.ard = ard; v.wd = wd; v.smp_we = smp_we; v.smp_d = smp_d;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_v1 = v1; v.e_v2 = v2; v.e_col = col;
        return v;
    endfunction

    vec_t idle;

    initial begin
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("rst_rd%0d", i), 1, 1, 1, 3'(i), 3'(7 - i), 0, 0, 0, 0, 0,
                              16'h0000, 16'h0000, 1, 1, 0));
        //                 name        en re1 re2 ar1 ar2 we ard wd        swe smp_d     rd1       rd2       v1 v2 col
        vecs.push_back(mk("wr3",        1, 0, 0, 0, 0, 1, 3, 16'h1234, 0, 0,        16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("rd3",        1, 1, 0, 3, 0, 0, 0, 0,        0, 0,        16'h1234, 16'h0000, 1, 0, 0));
        vecs.push_back(mk("wr5",        1, 0, 0, 0, 0, 1, 5, 16'h00AA, 0, 0,        16'h1234, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("wr6",        1, 0, 0, 0, 0, 1, 6, 16'h0055, 0, 0,        16'h1234, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("rd5_6",      1, 1, 1, 5, 6, 0, 0, 0,        0, 0,        16'h00AA, 16'h0055, 1, 1, 0));
        vecs.push_back(mk("rd6_6",      1, 1, 1, 6, 6, 0, 0, 0,        0, 0,        16'h0055, 16'h0055, 1, 1, 0));
        vecs.push_back(mk("coll0",      1, 0, 0, 0, 0, 1, 0, 16'h1111, 1, 16'h2222, 16'h0055, 16'h0055, 0, 0, 1));
        vecs.push_back(mk("rd0",        1, 1, 0, 0, 0, 0, 0, 0,        0, 0,        16'h2222, 16'h0055, 1, 0, 0));
        vecs.push_back(mk("nocoll4",    1, 0, 0, 0, 0, 1, 4, 16'h1111, 1, 16'h2222, 16'h2222, 16'h0055, 0, 0, 0));
        vecs.push_back(mk("rd4_0",      1, 1, 1, 4, 0, 0, 0, 0,        0, 0,        16'h1111, 16'h2222, 1, 1, 0));
        vecs.push_back(mk("wr2_1",      1, 0, 0, 0, 0, 1, 2, 16'h0001, 0, 0,        16'h1111, 16'h2222, 0, 0, 0));
        vecs.push_back(mk("rdw2",       1, 1, 0, 2, 0, 1, 2, 16'h0002, 0, 0,        BYP ? 16'h0002 : 16'h0001, 16'h2222, 1, 0, 0));
        vecs.push_back(mk("rd2_after",  1, 1, 0, 2, 0, 0, 0, 0,        0, 0,        16'h0002, 16'h2222, 1, 0, 0));
        vecs.push_back(mk("rdw_smp",    1, 0, 1, 0, 0, 0, 0, 0,        1, 16'h5A5A, 16'h0002, BYP ? 16'h5A5A : 16'h2222, 0, 1, 0));
        vecs.push_back(mk("rdw_coll",   1, 1, 0, 0, 0, 1, 0, 16'h9999, 1, 16'h6B6B, BYP ? 16'h6B6B : 16'h5A5A,
                          BYP ? 16'h5A5A : 16'h2222, 1, 0, 1));
        vecs.push_back(mk("rd0_0",      1, 1, 1, 0, 0, 0, 0, 0,        0, 0,        16'h6B6B, 16'h6B6B, 1, 1, 0));
        vecs.push_back(mk("en0_wr1",    0, 1, 0, 1, 0, 1, 1, 16'hBEEF, 1, 16'hFFFF, 16'h6B6B, 16'h6B6B, 0, 0, 0));
        vecs.push_back(mk("en0_coll",   0, 0, 1, 0, 0, 1, 0, 16'h1111, 1, 16'hFFFF, 16'h6B6B, 16'h6B6B, 0, 0, 0));
        vecs.push_back(mk("rd1_0_hold", 1, 1, 1, 1, 0, 0, 0, 0,        0, 0,        16'h0000, 16'h6B6B, 1, 1, 0));
        vecs.push_back(mk("en1_wr1",    1, 0, 0, 0, 0, 1, 1, 16'hBEEF, 0, 0,        16'h0000, 16'h6B6B, 0, 0, 0));
        vecs.push_back(mk("rd1",        1, 1, 0, 1, 0, 0, 0, 0,        0, 0,        16'hBEEF, 16'h6B6B, 1, 0, 0));

        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset mid-cycle: outputs must clear without a clock edge, write must not land.
        apply(mk("wr7",  1, 0, 0, 0, 0, 1, 7, 16'h7777, 0, 0,        16'hBEEF, 16'h6B6B, 0, 0, 0));
        apply(mk("pre",  1, 1, 1, 7, 7, 1, 0, 16'h1111, 1, 16'h2222, 16'h7777, 16'h7777, 1, 1, 1));
        @(negedge clk);
        drive(mk("mid", 1, 1, 1, 7, 7, 1, 7, 16'h1234, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 16'h0000, 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("rst_held", 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        apply(mk("rd7_post", 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/srs_regfile.md
Name: srs_regfile

Overview:
- Datapath register file sitting directly downstream of the controller's register-file address driver.
- Consumes the read addresses ar1/ar2 and the write address ard, and supplies operands to the MAC datapath.
- Accepts MAC results and error terms on the write port.
- Provides a dedicated sample-load port so new input samples land in a fixed register without going through the controller.

Parameters:
- WIDTH, 3, address width; the file holds 2**WIDTH entries.
- DATA_W, 16, data word width in bits.
- SAMPLE_REG, 0, index of the register written by the sample-load port.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  stage enable; when low, no reads, writes or flag updates occur.
- re1  in  1  read request, port 1.
- re2  in  1  read request, port 2.
- ar1  in  WIDTH  read address, port 1.
- ar2  in  WIDTH  read address, port 2.
- we  in  1  core write request.
- ard  in  WIDTH  core write address.
- wd  in  DATA_W  core write data.
- smp_we  in  1  sample-load write request.
- smp_d  in  DATA_W  sample data.
- rd1  out  DATA_W  registered read data, port 1.
- rd2  out  DATA_W  registered read data, port 2.
- rd1_vld  out  1  rd1 holds data for a read issued the previous cycle.
- rd2_vld  out  1  rd2 holds data for a read issued the previous cycle.
- wr_collide  out  1  one-cycle pulse when the core and sample writes target the same register.

Behaviour:
- Reset (rst=0, asynchronous): all 2**WIDTH entries clear to 0; rd1, rd2, rd1_vld, rd2_vld and wr_collide clear to 0. Reset mid-operation aborts any pending write, and no partial update survives.
- Enable gating: with en=0, the array, rd1 and rd2 hold their values. rd1_vld, rd2_vld and wr_collide are forced to 0 on that edge.
- Reads: with en=1 and reN=1, the edge captures entry[arN] into rdN and sets rdN_vld=1. Latency is 1 cycle from request to data. With reN=0, rdN holds its value and rdN_vld=0.
- Port independence: ar1 may equal ar2, and both ports return the same word.
- Core write: with en=1 and we=1, entry[ard] <= wd at the edge.
- Sample write: with en=1 and smp_we=1, entry[SAMPLE_REG] <= smp_d at the edge.
- Write collision: if we=1, smp_we=1 and ard==SAMPLE_REG in the same cycle, the sample write wins. The core data is dropped and wr_collide=1 for that one cycle. If ard!=SAMPLE_REG, both writes complete and wr_collide=0.
- Read-during-write: if a read address matches a write address in the same enabled cycle, the result depends on REGFILE_BYPASS_EN (see Optional Feature).
- Bypass priority: when bypassing, the sample write takes priority over the core write, matching the collision rule.
- Widths: addresses are used unsigned modulo 2**WIDTH with no out-of-range case. Data is stored and returned unmodified, with no arithmetic in this block.
- No internal state machine: the array plus the output registers are the only state. Throughput is one read per port plus one write per port every cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): a read whose address matches a same-cycle write returns the new write data in rdN. The winning write is used when a collision occurs.
- Undefined (read-first): a matching read returns the entry value from before the edge. The new value is visible to reads issued from the next cycle onward.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and basic write/read: after reset, read all 8 addresses on both ports -> every rdN=0x0000 with rdN_vld=1 one cycle later. Then write ard=3, wd=0x1234; next cycle read ar1=3 -> rd1=0x1234 one cycle later.
- Dual read: write 0x00AA to reg 5 and 0x0055 to reg 6; issue ar1=5, ar2=6, then ar1=ar2=6 -> rd1/rd2 show 0xAA/0x55, then 0x55/0x55, each one cycle after issue.
- Collision: we=1, ard=0, wd=0x1111 with smp_we=1, smp_d=0x2222 in the same cycle -> wr_collide=1 for exactly one cycle and reg 0 reads back 0x2222. Repeat with ard=4 -> wr_collide=0, reg 4 reads 0x1111 and reg 0 reads 0x2222.
- Read-during-write: reg 2=0x0001; same cycle write reg 2=0x0002 and read ar1=2 -> rd1=0x0002 with REGFILE_BYPASS_EN defined, rd1=0x0001 without it. The next read of reg 2 returns 0x0002 in both builds.
- Enable gating: en=0 with we=1, ard=1, wd=0xBEEF and re1=1 -> reg 1 unchanged, rd1 holds, rd1_vld=0. With en=1 the same write completes.
- Async reset mid-operation: write reg 7=0x7777, then assert rst between clock edges while we=1 -> outputs go to 0 immediately without waiting for an edge. After release, reg 7 reads 0x0000.
